// File: rtl/fp_dot_pipe.sv
// fp_dot_pipe: pipelined FP32 dot product (LANES products/beat, registered pairwise tree, K-loop accumulator)
module fp_dot_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_a,
  input  logic [LANES*32-1:0]   in_b,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [TAG_W-1:0]      out_tag
);
  localparam int L = $clog2(LANES);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  function automatic logic is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'd0;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 23'd0;
  endfunction

  // value = m / 2^49 * 2^(e-127); normalises, handles subnormal underflow, rounds to nearest even
  function automatic logic [31:0] round_pack(input logic s, input logic signed [12:0] e_in, input logic [49:0] m_in);
    logic [49:0] m;
    logic signed [12:0] e;
    logic [24:0] r;
    logic [32:0] tot;
    logic up;
    int lz;
    int sh;
    m = m_in;
    e = e_in;
    lz = 0;
    if (m == 50'd0) return {s, 31'd0};
    for (int i = 0; i < 50; i++) if (m[i]) lz = 49 - i;
    m = m << lz;
    e = e - 13'(lz);
    if (e < 13'sd1) begin
      sh = 1 - int'(e);
      m = sh >= 50 ? {49'd0, |m} : (m >> sh) | {49'd0, ((m >> sh) << sh) != m};
      e = 13'sd1;
    end
    if (e > 13'sd254) return {s, 8'hFF, 23'd0};
    up = m[25] & (m[26] | (|m[24:0]));
    r = {1'b0, m[49:26]} + {24'd0, up};
    // hidden bit in r[23] bumps the biased exponent, so subnormals and carries fall out naturally
    tot = {10'(e - 13'sd1), 23'd0} + {8'd0, r};
    return tot >= 33'h07F800000 ? {s, 8'hFF, 23'd0} : {s, tot[30:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb;
    logic [47:0] p;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && b[30:0] == 31'd0) || (is_inf(b) && a[30:0] == 31'd0)) return QNAN;
    if (is_inf(a) || is_inf(b)) return {a[31] ^ b[31], 8'hFF, 23'd0};
    ea = a[30:23] == 8'd0 ? 8'd1 : a[30:23];
    eb = b[30:23] == 8'd0 ? 8'd1 : b[30:23];
    p = 48'({|a[30:23], a[22:0]}) * 48'({|b[30:23], b[22:0]});
    return round_pack(a[31] ^ b[31], 13'(ea) + 13'(eb) - 13'd126, {p, 2'b00});
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0] ex, ey, d;
    logic [49:0] wx, wy, sy, sum;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    {x, y} = a[30:0] < b[30:0] ? {b, a} : {a, b};
    ex = x[30:23] == 8'd0 ? 8'd1 : x[30:23];
    ey = y[30:23] == 8'd0 ? 8'd1 : y[30:23];
    d = ex - ey;
    wx = {1'b0, |x[30:23], x[22:0], 25'd0};
    wy = {1'b0, |y[30:23], y[22:0], 25'd0};
    // bits shifted out of the smaller operand collapse into a sticky LSB
    sy = d >= 8'd50 ? {49'd0, |wy} : (wy >> d) | {49'd0, ((wy >> d) << d) != wy};
    sum = x[31] == y[31] ? wx + sy : wx - sy;
    return round_pack(sum == 50'd0 ? x[31] & y[31] : x[31], 13'(ex) + 13'd1, sum);
  endfunction

  logic                adv;
  logic [31:0]         node [1:2*LANES-1];
  logic [L:0]          vld, fst, lst;
  logic [TAG_W-1:0]    tag [L+1];
  logic [31:0]         acc, acc_nxt;

  assign adv = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign acc_nxt = fst[L] ? node[1] : fp_add(acc, node[1]);

  always_ff @(posedge clk)
    if (reset) vld <= '0;
    else if (adv) vld <= {vld[L-1:0], in_valid};

  // heap-ordered tree: leaves at LANES+i, node n sums children 2n and 2n+1, root at 1
  always_ff @(posedge clk)
    if (adv) begin
      for (int i = 0; i < LANES; i++)
        node[LANES+i] <= in_mask[i] ? fp_mul(in_a[32*i +: 32], in_b[32*i +: 32]) : 32'd0;
      for (int n = 1; n < LANES; n++)
        node[n] <= fp_add(node[2*n], node[2*n+1]);
      fst <= {fst[L-1:0], in_first};
      lst <= {lst[L-1:0], in_last};
      tag[0] <= in_tag;
      for (int k = 1; k <= L; k++) tag[k] <= tag[k-1];
    end

  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
    end else if (adv) begin
      if (vld[L]) acc <= acc_nxt;
      out_valid <= vld[L] & lst[L];
      if (vld[L] & lst[L]) begin
        out_data <= acc_nxt;
        out_tag <= tag[L];
      end
    end
endmodule
